// File: rtl/axi4_regbank_pkg.sv
// axi4_regbank_pkg: bus widths, FSM state types, response codes and address decode helpers
package axi4_regbank_pkg;
  localparam int ALEN = 32;
  localparam int XLEN = 32;
  localparam int IDLEN = 5;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} WrState_t;
  typedef enum logic {R_IDLE, R_DATA} RdState_t;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  function automatic logic [ALEN-2:0] reg_idx(input logic [ALEN-1:0] addr, input logic [ALEN-1:0] base);
    return (ALEN-1)'((addr - base) >> 2);
  endfunction
endpackage

// File: rtl/axi4_regbank_if.sv
// axi4_regbank_if: AXI4 aw/w/b/ar/r channels with master (initiator) and slave (responder) modports
interface axi4_regbank_if;
  import axi4_regbank_pkg::*;
  logic aw_valid, aw_ready;
  logic [ALEN-1:0] aw_addr;
  logic [IDLEN-1:0] aw_id;
  logic [7:0] aw_len;
  logic w_valid, w_ready, w_last;
  logic [XLEN-1:0] w_data;
  logic [XLEN/8-1:0] w_strb;
  logic b_valid, b_ready;
  logic [IDLEN-1:0] b_id;
  logic [1:0] b_resp;
  logic ar_valid, ar_ready;
  logic [ALEN-1:0] ar_addr;
  logic [IDLEN-1:0] ar_id;
  logic [7:0] ar_len;
  logic r_valid, r_ready, r_last;
  logic [XLEN-1:0] r_data;
  logic [IDLEN-1:0] r_id;
  logic [1:0] r_resp;
  modport master (
    output aw_valid, aw_addr, aw_id, aw_len, w_valid, w_data, w_strb, w_last, b_ready,
           ar_valid, ar_addr, ar_id, ar_len, r_ready,
    input  aw_ready, w_ready, b_valid, b_id, b_resp, ar_ready, r_valid, r_data, r_id, r_resp, r_last
  );
  modport slave (
    input  aw_valid, aw_addr, aw_id, aw_len, w_valid, w_data, w_strb, w_last, b_ready,
           ar_valid, ar_addr, ar_id, ar_len, r_ready,
    output aw_ready, w_ready, b_valid, b_id, b_resp, ar_ready, r_valid, r_data, r_id, r_resp, r_last
  );
endinterface

// File: rtl/axi4_regbank_rd.sv
// axi4_regbank_rd: INCR-burst read engine; ports clk, rst_n, bus (ar/r), regs and status beat sources
module axi4_regbank_rd
  import axi4_regbank_pkg::*;
#(
  parameter logic [ALEN-1:0] REG_ADDR_MAP = '0,
  parameter int NREGS = 8,
  parameter logic [NREGS-1:0] RO_MASK = '0
) (
  input logic clk,
  input logic rst_n,
  axi4_regbank_if.slave bus,
  input logic [NREGS-1:0][XLEN-1:0] regs,
  input logic [NREGS-1:0][XLEN-1:0] status
);
  localparam int IW = idx_w(NREGS);
  localparam logic [ALEN-2:0] NR = (ALEN-1)'(NREGS);
  RdState_t rs, rs_n;
  logic live, ar_hs, r_hs, ld, n_oor;
  logic [ALEN-2:0] r_idx, n_idx;
  logic [7:0] r_len, r_beat;
  logic [IW-1:0] ni;
  assign bus.ar_ready = live && rs == R_IDLE;
  assign bus.r_valid = rs == R_DATA;
  assign bus.r_last = r_beat == r_len;
  assign ar_hs = bus.ar_valid && bus.ar_ready;
  assign r_hs = bus.r_valid && bus.r_ready;
  assign ld = ar_hs || (r_hs && !bus.r_last);
  assign n_idx = ar_hs ? reg_idx(bus.ar_addr, REG_ADDR_MAP) : r_idx + 1'b1;
  assign ni = n_idx[IW-1:0];
  assign n_oor = n_idx >= NR;
  always_comb begin
    rs_n = ar_hs ? R_DATA : r_hs && bus.r_last ? R_IDLE : rs;
  end
  always_ff @(posedge clk) begin
    live <= rst_n;
    rs <= rst_n ? rs_n : R_IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_idx <= '0;
      r_len <= '0;
      r_beat <= '0;
      bus.r_id <= '0;
      bus.r_data <= '0;
      bus.r_resp <= RESP_OKAY;
    end else begin
      if (ar_hs) begin
        bus.r_id <= bus.ar_id;
        r_len <= bus.ar_len;
      end
      if (ld) begin
        r_idx <= n_idx;
        r_beat <= ar_hs ? 8'd0 : r_beat + 8'd1;
        bus.r_data <= n_oor ? '0 : RO_MASK[ni] ? status[ni] : regs[ni];
        bus.r_resp <= n_oor ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end
endmodule

// File: rtl/axi4_regbank.sv
// axi4_regbank: AXI4 register bank responder; ports clk, rst_n, bus (slave), regs_o, wr_pulse_o, status_i
module axi4_regbank
  import axi4_regbank_pkg::*;
#(
  parameter logic [ALEN-1:0] REG_ADDR_MAP = 32'h0,
  parameter int NREGS = 8,
  parameter logic [NREGS-1:0] RO_MASK = '0
) (
  input logic clk,
  input logic rst_n,
  axi4_regbank_if.slave bus,
  output logic [NREGS-1:0][XLEN-1:0] regs_o,
  output logic [NREGS-1:0] wr_pulse_o,
  input logic [NREGS-1:0][XLEN-1:0] status_i
);
  localparam int IW = idx_w(NREGS);
  localparam logic [ALEN-2:0] NR = (ALEN-1)'(NREGS);
  WrState_t ws, ws_n;
  logic live, w_err, aw_hs, w_hs, w_ok, w_end;
  logic [IDLEN-1:0] w_id;
  logic [ALEN-2:0] w_idx;
  logic [7:0] w_len, w_beat;
  logic [IW-1:0] wi;
  assign bus.aw_ready = live && ws == W_IDLE;
  assign bus.w_ready = ws == W_DATA;
  assign bus.b_valid = ws == W_RESP;
  assign bus.b_id = w_id;
  assign bus.b_resp = w_err ? RESP_SLVERR : RESP_OKAY;
  assign aw_hs = bus.aw_valid && bus.aw_ready;
  assign w_hs = bus.w_valid && bus.w_ready;
  assign w_end = w_beat == w_len;
  assign wi = w_idx[IW-1:0];
  assign w_ok = w_idx < NR && !RO_MASK[wi];
  always_comb begin
    ws_n = aw_hs ? W_DATA : w_hs && w_end ? W_RESP : bus.b_valid && bus.b_ready ? W_IDLE : ws;
  end
  always_ff @(posedge clk) begin
    live <= rst_n;
    ws <= rst_n ? ws_n : W_IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      regs_o <= '0;
      wr_pulse_o <= '0;
      w_err <= 1'b0;
      w_id <= '0;
      w_idx <= '0;
      w_len <= '0;
      w_beat <= '0;
    end else begin
      wr_pulse_o <= '0;
      if (aw_hs) begin
        w_id <= bus.aw_id;
        w_idx <= reg_idx(bus.aw_addr, REG_ADDR_MAP);
        w_len <= bus.aw_len;
        w_beat <= '0;
        w_err <= 1'b0;
      end
      if (w_hs) begin
        if (w_ok) begin
          for (int b = 0; b < XLEN/8; b++)
            if (bus.w_strb[b]) regs_o[wi][8*b +: 8] <= bus.w_data[8*b +: 8];
          wr_pulse_o[wi] <= 1'b1;
        end
        if (!w_ok || bus.w_last != w_end) w_err <= 1'b1;
        w_idx <= w_idx + 1'b1;
        w_beat <= w_beat + 8'd1;
      end
    end
  end
  axi4_regbank_rd #(
    .REG_ADDR_MAP(REG_ADDR_MAP),
    .NREGS(NREGS),
    .RO_MASK(RO_MASK)
  ) u_rd (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .regs(regs_o),
    .status(status_i)
  );
endmodule

// File: tb/tb_axi4_regbank.sv
// tb_axi4_regbank: directed scoreboard bench for axi4_regbank
module tb_axi4_regbank;
  import axi4_regbank_pkg::*;
  localparam logic [31:0] BASE = 32'h1000;
  localparam int N = 8;
  typedef struct packed {logic [4:0] id; logic [1:0] resp;} b_t;
  typedef struct packed {logic [4:0] id; logic [31:0] data; logic [1:0] resp; logic last;} r_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0][31:0] regs_o, status_i, snap;
  logic [N-1:0] wr_pulse_o;
  int n_cmp = 0;
  int n_err = 0;
  b_t bq[$];
  r_t rq[$];
  b_t be;
  r_t re;
  axi4_regbank_if bus();
  axi4_regbank #(
    .REG_ADDR_MAP(BASE),
    .NREGS(N),
    .RO_MASK(8'h01)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .regs_o(regs_o),
    .wr_pulse_o(wr_pulse_o),
    .status_i(status_i)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic er(input logic [4:0] id, input logic [31:0] d, input logic [1:0] resp, input logic last);
    rq.push_back(r_t'{id, d, resp, last});
  endtask
  always @(negedge clk) begin
    if (bus.b_valid && bus.b_ready) begin
      if (bq.size() == 0) chk("b_unexpected", 1, 0);
      else begin
        be = bq.pop_front();
        chk("b_id", bus.b_id, be.id);
        chk("b_resp", bus.b_resp, be.resp);
      end
    end
    if (bus.r_valid && bus.r_ready) begin
      if (rq.size() == 0) chk("r_unexpected", 1, 0);
      else begin
        re = rq.pop_front();
        chk("r_id", bus.r_id, re.id);
        chk("r_data", bus.r_data, re.data);
        chk("r_resp", bus.r_resp, re.resp);
        chk("r_last", bus.r_last, re.last);
      end
    end
  end
  task automatic wr(input logic [31:0] a, input logic [4:0] id, input logic [7:0] len,
                    input logic [31:0] d0, input logic [3:0] strb, input logic [1:0] resp, input int pi);
    int t;
    bq.push_back(b_t'{id, resp});
    bus.aw_valid = 1'b1;
    bus.aw_addr = a;
    bus.aw_id = id;
    bus.aw_len = len;
    t = 0;
    while (!bus.aw_ready && t < 50) begin tick(); t++; end
    if (t >= 50) chk("aw_timeout", 0, 1);
    tick();
    bus.aw_valid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      bus.w_valid = 1'b1;
      bus.w_data = d0 + i;
      bus.w_strb = strb;
      bus.w_last = i == int'(len);
      t = 0;
      while (!bus.w_ready && t < 50) begin tick(); t++; end
      if (t >= 50) chk("w_timeout", 0, 1);
      tick();
    end
    bus.w_valid = 1'b0;
    bus.w_last = 1'b0;
    chk("b_valid_rise", bus.b_valid, 1);
    if (pi >= 0) chk("wr_pulse_on", wr_pulse_o, 64'(1) << pi);
    bus.b_ready = 1'b1;
    t = 0;
    while (!bus.b_valid && t < 50) begin tick(); t++; end
    if (t >= 50) chk("b_timeout", 0, 1);
    tick();
    bus.b_ready = 1'b0;
    if (pi >= 0) chk("wr_pulse_off", wr_pulse_o, 0);
  endtask
  task automatic rd(input logic [31:0] a, input logic [4:0] id, input logic [7:0] len,
                    input int stall, input logic [31:0] hold_exp);
    int t;
    bus.ar_valid = 1'b1;
    bus.ar_addr = a;
    bus.ar_id = id;
    bus.ar_len = len;
    t = 0;
    while (!bus.ar_ready && t < 50) begin tick(); t++; end
    if (t >= 50) chk("ar_timeout", 0, 1);
    tick();
    bus.ar_valid = 1'b0;
    chk("r_valid_ar1", bus.r_valid, 1);
    for (int i = 0; i <= int'(len); i++) begin
      t = 0;
      while (!bus.r_valid && t < 50) begin tick(); t++; end
      if (t >= 50) chk("r_timeout", 0, 1);
      if (i == stall) begin
        bus.r_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
          tick();
          chk("r_hold", bus.r_data, hold_exp);
        end
      end
      bus.r_ready = 1'b1;
      tick();
    end
    bus.r_ready = 1'b0;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    status_i = '0;
    status_i[0] = 32'hCAFE;
    {bus.aw_valid, bus.w_valid, bus.w_last, bus.b_ready, bus.ar_valid, bus.r_ready} = '0;
    {bus.aw_addr, bus.aw_id, bus.aw_len, bus.ar_addr, bus.ar_id, bus.ar_len} = '0;
    bus.w_data = '0;
    bus.w_strb = '0;
    repeat (3) tick();
    chk("rst_aw_ready", bus.aw_ready, 0);
    chk("rst_ar_ready", bus.ar_ready, 0);
    chk("rst_b_valid", bus.b_valid, 0);
    chk("rst_r_valid", bus.r_valid, 0);
    chk("rst_regs_zero", regs_o == '0, 1);
    chk("rst_pulse", wr_pulse_o, 0);
    rst_n = 1'b1;
    tick();
    chk("aw_ready_up", bus.aw_ready, 1);
    chk("ar_ready_up", bus.ar_ready, 1);
    wr(BASE + 4, 5'd3, 8'd0, 32'hDEADBEEF, 4'hF, RESP_OKAY, 1);
    chk("reg1", regs_o[1], 32'hDEADBEEF);
    wr(BASE + 8, 5'd4, 8'd0, 32'h11223344, 4'hF, RESP_OKAY, 2);
    wr(BASE + 8, 5'd5, 8'd0, 32'hAABBCCDD, 4'b0010, RESP_OKAY, 2);
    chk("reg2_merge", regs_o[2], 32'h1122CC44);
    wr(BASE + 12, 5'd6, 8'd0, 32'h33333333, 4'hF, RESP_OKAY, 3);
    er(5'd7, 32'hCAFE, RESP_OKAY, 1'b0);
    er(5'd7, 32'hDEADBEEF, RESP_OKAY, 1'b0);
    er(5'd7, 32'h1122CC44, RESP_OKAY, 1'b0);
    er(5'd7, 32'h33333333, RESP_OKAY, 1'b1);
    rd(BASE, 5'd7, 8'd3, 2, 32'h1122CC44);
    snap = regs_o;
    wr(BASE + 32, 5'd8, 8'd0, 32'h99999999, 4'hF, RESP_SLVERR, -1);
    chk("oor_no_change", regs_o == snap, 1);
    er(5'd9, 32'h0, RESP_SLVERR, 1'b1);
    rd(BASE + 32, 5'd9, 8'd0, -1, 32'h0);
    er(5'd10, 32'h0, RESP_SLVERR, 1'b1);
    rd(BASE - 4, 5'd10, 8'd0, -1, 32'h0);
    wr(BASE + 28, 5'd11, 8'd1, 32'h77770000, 4'hF, RESP_SLVERR, -1);
    chk("reg7_edge", regs_o[7], 32'h77770000);
    er(5'd12, 32'h77770000, RESP_OKAY, 1'b0);
    er(5'd12, 32'h0, RESP_SLVERR, 1'b1);
    rd(BASE + 28, 5'd12, 8'd1, -1, 32'h0);
    wr(BASE, 5'd13, 8'd0, 32'h12345678, 4'hF, RESP_SLVERR, -1);
    chk("reg0_ro", regs_o[0], 32'h0);
    er(5'd14, 32'hCAFE, RESP_OKAY, 1'b1);
    rd(BASE, 5'd14, 8'd0, -1, 32'h0);
    er(5'd16, 32'hDEADBEEF, RESP_OKAY, 1'b0);
    er(5'd16, 32'h1122CC44, RESP_OKAY, 1'b1);
    fork
      wr(BASE + 16, 5'd15, 8'd2, 32'h40404040, 4'hF, RESP_OKAY, -1);
      rd(BASE + 4, 5'd16, 8'd1, -1, 32'h0);
    join
    chk("reg4", regs_o[4], 32'h40404040);
    chk("reg5", regs_o[5], 32'h40404041);
    chk("reg6", regs_o[6], 32'h40404042);
    bus.aw_valid = 1'b1;
    bus.aw_addr = BASE + 20;
    bus.aw_id = 5'd17;
    bus.aw_len = 8'd2;
    tick();
    bus.aw_valid = 1'b0;
    bus.w_valid = 1'b1;
    bus.w_data = 32'h55555555;
    bus.w_strb = 4'hF;
    bus.w_last = 1'b0;
    tick();
    chk("mid_reg5", regs_o[5], 32'h55555555);
    bus.w_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    chk("mid_rst_regs", regs_o == '0, 1);
    chk("mid_rst_pulse", wr_pulse_o, 0);
    chk("mid_rst_b_valid", bus.b_valid, 0);
    chk("mid_rst_r_valid", bus.r_valid, 0);
    chk("mid_rst_aw_ready", bus.aw_ready, 0);
    chk("mid_rst_ar_ready", bus.ar_ready, 0);
    rst_n = 1'b1;
    bus.b_ready = 1'b1;
    repeat (4) begin
      tick();
      chk("no_b_after_rst", bus.b_valid, 0);
    end
    bus.b_ready = 1'b0;
    chk("aw_ready_after_rst", bus.aw_ready, 1);
    repeat (3) tick();
    chk("bq_drained", bq.size(), 0);
    chk("rq_drained", rq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/axi4_regbank.md
# axi4_regbank

AXI4 responder exposing a bank of NREGS 32-bit memory-mapped registers at a base address. It is the target-side counterpart of the AXI4 initiators that program peripherals, and the common register front end for new peripherals. Write and read channels are independent engines with INCR burst support, byte strobes, and per-register read-only masking. Error responses flag out-of-range or read-only accesses.

## Interface
- REG_ADDR_MAP, 32'h0: base byte address of register 0.
- NREGS, 8: number of 32-bit registers (1..64).
- RO_MASK, '0 (NREGS bits): bit i set makes register i read-only; its read data comes from status_i[i].
- clk  in  1  sole clock, all logic on posedge.
- rst_n  in  1  reset, synchronous and active-low.
- bus  axi4 interface (alen=32, xlen=32, idlen=5), responder side. Fields used: aw.addr/id/len, w.data/strb/last, b.id/resp, ar.addr/id/len, r.data/id/resp/last, plus all valid/ready.
- regs_o  out  NREGS x 32  current register contents.
- wr_pulse_o  out  NREGS  one-cycle strobe per register, asserted the cycle after a write beat lands in that register.
- status_i  in  NREGS x 32  hardware values returned for RO registers.

## Operation
- Decode: off = addr - REG_ADDR_MAP; idx = off[31:2]. Low two address bits are ignored. idx >= NREGS means out of range.
- Write FSM, states W_IDLE, W_DATA, W_RESP:
  - W_IDLE: aw_ready=1, w_ready=0. An AW handshake latches id, idx, and len, clears err and beat count, then moves to W_DATA.
  - W_DATA: w_ready=1. Each W handshake writes strb-selected bytes of w.data into regs[idx] if idx is in range and not RO; otherwise it sets sticky err and writes nothing. Then idx+1 and beat+1.
  - On the beat where beat==len, move to W_RESP. If w.last does not match (beat==len) on any beat, set err. The count governs termination, not w.last.
  - W_RESP: b_valid=1, b.id=latched id, b.resp = err ? SLVERR(2'b10) : OKAY(2'b00). Hold until b_ready, then go to W_IDLE.
- Read FSM, states R_IDLE, R_DATA:
  - R_IDLE: ar_ready=1. An AR handshake latches id, idx, and len, loads the beat-0 data register, then moves to R_DATA.
  - R_DATA: r_valid=1 with r.id, r.data, r.resp, and r.last=(beat==len). Per-beat data: out of range gives 0 with SLVERR; RO gives status_i[idx] with OKAY; otherwise regs[idx] with OKAY.
  - On an R handshake: if last, go to R_IDLE; else idx+1, beat+1, and load the next beat.
- Indices never wrap. They increment past NREGS-1 and become out-of-range (SLVERR) beats.
- Only INCR bursts are supported; aw/ar burst type and size are ignored (32-bit beats).
- Reads and writes run concurrently and never block each other.

## Timing
- Reset (rst_n low at posedge): both FSMs go to IDLE, regs_o=0, wr_pulse_o=0, b_valid=0, r_valid=0, aw_ready=0, ar_ready=0. The ready signals rise the first cycle after reset deasserts.
- Reset mid-burst aborts the transaction silently; no B or R is issued afterwards.
- Write: AW handshake at cycle N; w_ready=1 from N+1. Register update and wr_pulse_o occur at the edge ending the W handshake cycle. b_valid rises the cycle after the last W handshake.
- Read: AR handshake at cycle N gives r_valid at N+1. With r_ready held high, one beat per cycle.
- r.data/resp/last stay stable while r_valid && !r_ready. b fields stay stable while b_valid && !b_ready.
- Read and write to the same register in the same cycle: the read beat carries the pre-write value if its data loaded that cycle, otherwise the new value.
- Minimum single-beat write turnaround is 3 cycles (AW, W, B). Minimum single-beat read is 2 cycles.

## Structure
- axi4_regbank_pkg holds the WrState_t and RdState_t enums, RESP_OKAY/RESP_SLVERR constants, and the idx width function.
- One sub-module, axi4_regbank_rd, contains the read FSM and beat-data mux. The write FSM and register array stay in the top level.

## Test plan
- Single write: 0x0004 with data 0xDEADBEEF, strb 0xF. Expect b.resp=OKAY with matching b.id, regs_o[1]=0xDEADBEEF, and wr_pulse_o[1] high for exactly one cycle.
- Strobe merge: regs[2]=0x11223344, write 0xAABBCCDD with strb 4'b0010. Expect regs[2]=0x1122CC44.
- Read burst: ar addr base, len=3, regs[0..3] preloaded. Expect 4 beats in order, r.last only on beat 4, and r_valid at AR+1. Hold r_ready low for 5 cycles mid-burst; r.data must stay stable.
- Errors: write to base+NREGS*4 gives SLVERR and no register changes; read there gives data 0 with SLVERR. A write burst at idx NREGS-1 with len=1 updates the last register and returns SLVERR.
- RO: with RO_MASK bit 0 set and status_i[0]=0xCAFE, a write to reg0 gives SLVERR and regs_o[0] unchanged; a read gives 0xCAFE with OKAY.
- Concurrency and reset: overlapping read and write bursts both complete correctly. rst_n low during W_DATA gives all outputs 0 and no B response.
